// File: rtl/mem_responder.sv
// Single-port memory-mapped responder: word RAM in the low half of the address map,
// an LED register and a switch port in the high half, with a fixed wait-state count.
module mem_responder #(
    parameter int         AW          = 8,
    parameter int         DW          = 16,
    parameter int         WAIT_STATES = 0,
    parameter logic [8:0] LED_ADDR    = 9'h100,
    parameter logic [8:0] SW_ADDR     = 9'h140
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mem_cmd,
    input  logic [8:0]    mem_addr,
    input  logic [DW-1:0] write_data,
    input  logic [7:0]    switches,
    output logic [DW-1:0] read_data,
    output logic          mem_ready,
    output logic [7:0]    leds,
    output logic          err
);

    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b11;
    localparam logic [1:0] CMD_RSVD  = 2'b01;
    localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0] CNT_INIT  = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // High-half accesses are legal only as a LED write or a switch read.
    function automatic logic access_illegal(input logic is_wr, input logic [8:0] a);
        logic ill;
        if (!a[8]) begin
            ill = 1'b0;
        end else if (is_wr) begin
            ill = (a != LED_ADDR);
        end else begin
            ill = (a != SW_ADDR);
        end
        return ill;
    endfunction

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [8:0]    addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] read_data_q, read_data_d;
    logic          mem_ready_q, mem_ready_d;
    logic [7:0]    leds_q, leds_d;
    logic          err_q, err_d;

    logic [DW-1:0] ram_q [2**AW];

    logic          start_s;
    logic          rsvd_s;
    logic          finish_s;
    logic          acc_wr_s;
    logic [8:0]    acc_addr_s;
    logic [DW-1:0] acc_wdata_s;
    logic          illegal_s;
    logic          ram_hit_s;
    logic          ram_we_s;
    logic [DW-1:0] ram_rdata_s;

    // Command decode and the effective access; with no wait states the access
    // completes on the sampling edge itself, so it must see the live inputs.
    always_comb begin
        start_s     = 1'b0;
        rsvd_s      = 1'b0;
        acc_wr_s    = wr_q;
        acc_addr_s  = addr_q;
        acc_wdata_s = wdata_q;
        if (state_q == ST_IDLE) begin
            start_s     = (mem_cmd == CMD_READ) || (mem_cmd == CMD_WRITE);
            rsvd_s      = (mem_cmd == CMD_RSVD);
            acc_wr_s    = (mem_cmd == CMD_WRITE);
            acc_addr_s  = mem_addr;
            acc_wdata_s = write_data;
        end else begin
            start_s     = 1'b0;
            rsvd_s      = 1'b0;
        end
    end

    // The edge that moves the FSM into DONE is the edge that performs the access.
    always_comb begin
        finish_s = 1'b0;
        case (state_q)
            ST_IDLE: finish_s = start_s && !HAS_WAIT;
            ST_BUSY: finish_s = (cnt_q == 4'd0);
            ST_DONE: finish_s = 1'b0;
            default: finish_s = 1'b0;
        endcase
    end

    // Address classification and RAM port signals.
    always_comb begin
        illegal_s   = access_illegal(acc_wr_s, acc_addr_s);
        ram_hit_s   = !acc_addr_s[8];
        ram_rdata_s = ram_q[acc_addr_s[AW-1:0]];
        ram_we_s    = finish_s && acc_wr_s && ram_hit_s && reset;
    end

    // Next-state, capture and output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        leds_d      = leds_q;
        mem_ready_d = finish_s;
        err_d       = rsvd_s || (finish_s && illegal_s);

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    wr_d    = acc_wr_s;
                    addr_d  = mem_addr;
                    wdata_d = write_data;
                    if (HAS_WAIT) begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_DONE;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (finish_s) begin
            if (!acc_wr_s) begin
                if (illegal_s) begin
                    read_data_d = '0;
                end else if (ram_hit_s) begin
                    read_data_d = ram_rdata_s;
                end else begin
                    read_data_d = DW'(switches);
                end
            end else if (!illegal_s && !ram_hit_s) begin
                leds_d = acc_wdata_s[7:0];
            end else begin
                leds_d = leds_q;
            end
        end else begin
            read_data_d = read_data_q;
        end
    end

    // Control and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= 9'd0;
            wdata_q     <= '0;
            read_data_q <= '0;
            mem_ready_q <= 1'b0;
            leds_q      <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            mem_ready_q <= mem_ready_d;
            leds_q      <= leds_d;
            err_q       <= err_d;
        end
    end

    // RAM storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_q[acc_addr_s[AW-1:0]] <= acc_wdata_s;
        end
    end

    assign read_data = read_data_q;
    assign mem_ready = mem_ready_q;
    assign leds      = leds_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized plus directed bench: one responder with no wait states and 16 aliased
// RAM words, one with three wait states and 256 words, both against a simple memory model.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic [1:0]  cmd   [2];
    logic [8:0]  addr  [2];
    logic [15:0] wdata [2];
    logic [7:0]  sw    [2];
    logic [15:0] rdata [2];
    logic        ready [2];
    logic [7:0]  leds  [2];
    logic        err   [2];

    mem_responder #(.AW(4), .DW(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst_n[0]), .mem_cmd(cmd[0]), .mem_addr(addr[0]),
        .write_data(wdata[0]), .switches(sw[0]), .read_data(rdata[0]),
        .mem_ready(ready[0]), .leds(leds[0]), .err(err[0])
    );

    mem_responder #(.AW(8), .DW(16), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(rst_n[1]), .mem_cmd(cmd[1]), .mem_addr(addr[1]),
        .write_data(wdata[1]), .switches(sw[1]), .read_data(rdata[1]),
        .mem_ready(ready[1]), .leds(leds[1]), .err(err[1])
    );

    int          ws    [2] = '{0, 3};
    int          depth [2] = '{16, 256};
    logic [15:0] ram_m [2][256];
    logic [15:0] rd_m  [2];
    logic [7:0]  leds_m[2];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input int d);
        chk({tag, "_rdata"}, d, 32'(rdata[d]), 32'(rd_m[d]));
        chk({tag, "_leds"},  d, 32'(leds[d]),  32'(leds_m[d]));
    endtask

    // One bus transaction: drive, sample, optionally disturb inputs, then check the result.
    task automatic op(input int d, input logic [1:0] c, input logic [8:0] a,
                      input logic [15:0] wd, input logic [7:0] s, input bit perturb);
        bit is_wr;
        bit ill;
        int n;
        @(negedge clk);
        cmd[d] = c; addr[d] = a; wdata[d] = wd; sw[d] = s;
        @(posedge clk); #1;
        cmd[d] = 2'b00;
        if (perturb) begin
            addr[d]  = a + 9'd1;
            wdata[d] = ~wd;
        end
        if (c == 2'b01) begin
            chk("rsvd_err", d, 32'(err[d]), 32'd1);
            chk("rsvd_ready", d, 32'(ready[d]), 32'd0);
            chk_regs("rsvd", d);
            @(posedge clk); #1;
            chk("rsvd_err_end", d, 32'(err[d]), 32'd0);
            chk("rsvd_ready_end", d, 32'(ready[d]), 32'd0);
        end else if (c == 2'b00) begin
            chk("none_ready", d, 32'(ready[d]), 32'd0);
            chk("none_err", d, 32'(err[d]), 32'd0);
        end else begin
            is_wr = (c == 2'b11);
            ill   = 1'b0;
            if (!a[8]) begin
                if (is_wr) ram_m[d][a % depth[d]] = wd;
                else       rd_m[d] = ram_m[d][a % depth[d]];
            end else if (is_wr && a == 9'h100) begin
                leds_m[d] = wd[7:0];
            end else if (!is_wr && a == 9'h140) begin
                rd_m[d] = {8'h00, s};
            end else begin
                ill = 1'b1;
                if (!is_wr) rd_m[d] = 16'h0000;
            end
            n = 1;
            while (ready[d] !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("latency", d, 32'(n), 32'(ws[d] + 1));
            chk("err", d, 32'(err[d]), 32'(ill));
            chk_regs("acc", d);
            @(posedge clk); #1;
            chk("ready_pulse", d, 32'(ready[d]), 32'd0);
            chk("err_pulse", d, 32'(err[d]), 32'd0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; cmd[d] = 2'b00; addr[d] = 9'd0; wdata[d] = 16'd0; sw[d] = 8'd0;
            rd_m[d] = 16'd0; leds_m[d] = 8'd0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", d, 32'(ready[d]), 32'd0);
            chk("rst_err", d, 32'(err[d]), 32'd0);
            chk_regs("rst", d);
        end
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        for (int d = 0; d < 2; d++)
            for (int j = 0; j < depth[d]; j++)
                op(d, 2'b11, 9'(j), 16'($urandom), 8'd0, 1'b0);

        // No wait states: write/read, aliasing, back-to-back commands.
        op(0, 2'b11, 9'h005, 16'hABCD, 8'd0, 1'b0);
        op(0, 2'b10, 9'h005, 16'h0000, 8'd0, 1'b0);
        op(0, 2'b10, 9'h015, 16'h0000, 8'd0, 1'b0);
        @(negedge clk);
        cmd[0] = 2'b11; addr[0] = 9'h007; wdata[0] = 16'h5A5A;
        @(posedge clk); #1;
        chk("b2b_wr_ready", 0, 32'(ready[0]), 32'd1);
        cmd[0] = 2'b10; wdata[0] = 16'h0000;
        ram_m[0][7] = 16'h5A5A; rd_m[0] = 16'h5A5A;
        @(posedge clk); #1;
        chk("b2b_gap", 0, 32'(ready[0]), 32'd0);
        @(posedge clk); #1;
        chk("b2b_rd_ready", 0, 32'(ready[0]), 32'd1);
        chk("b2b_rd_data", 0, 32'(rdata[0]), 32'h5A5A);
        @(posedge clk); #1;
        chk("b2b_gap2", 0, 32'(ready[0]), 32'd0);
        @(posedge clk); #1;
        chk("b2b_repeat", 0, 32'(ready[0]), 32'd1);
        cmd[0] = 2'b00;
        @(posedge clk); #1;
        chk("b2b_end", 0, 32'(ready[0]), 32'd0);

        // Peripheral and illegal accesses on both instances.
        for (int d = 0; d < 2; d++) begin
            op(d, 2'b11, 9'h100, 16'h00A5, 8'h00, 1'b0);
            op(d, 2'b10, 9'h140, 16'h0000, 8'h3C, 1'b0);
            op(d, 2'b10, 9'h1FF, 16'h0000, 8'h3C, 1'b0);
            op(d, 2'b01, 9'h005, 16'h0000, 8'h3C, 1'b0);
            op(d, 2'b11, 9'h140, 16'hFFFF, 8'h3C, 1'b0);
            op(d, 2'b10, 9'h100, 16'h0000, 8'h3C, 1'b0);
        end

        // Wait states: address changed mid-transaction must not matter.
        op(1, 2'b11, 9'h005, 16'h1234, 8'd0, 1'b0);
        op(1, 2'b11, 9'h006, 16'h5678, 8'd0, 1'b0);
        op(1, 2'b10, 9'h005, 16'h0000, 8'd0, 1'b1);

        // Reset during BUSY of a write aborts it.
        op(1, 2'b11, 9'h010, 16'h2222, 8'd0, 1'b0);
        op(1, 2'b11, 9'h100, 16'h005A, 8'd0, 1'b0);
        @(negedge clk);
        cmd[1] = 2'b11; addr[1] = 9'h010; wdata[1] = 16'h1111;
        @(posedge clk); #1;
        cmd[1] = 2'b00;
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        #1;
        rd_m[1] = 16'h0000; leds_m[1] = 8'h00;
        chk("abort_ready", 1, 32'(ready[1]), 32'd0);
        chk("abort_err", 1, 32'(err[1]), 32'd0);
        chk_regs("abort", 1);
        @(negedge clk);
        rst_n[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("abort_no_ready", 1, 32'(ready[1]), 32'd0);
        end
        op(1, 2'b10, 9'h010, 16'h0000, 8'd0, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            int          d;
            int          r;
            logic [1:0]  c;
            logic [8:0]  a;
            d = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            c = (r < 4) ? 2'b10 : (r < 7) ? 2'b11 : (r == 7) ? 2'b01 : 2'b00;
            case ($urandom_range(0, 7))
                5:       a = 9'h100;
                6:       a = 9'h140;
                7:       a = {1'b1, 8'($urandom)};
                default: a = {1'b0, 8'($urandom)};
            endcase
            op(d, c, a, 16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
